shift_seq: RTL



---
 rtl/shift_pkg.sv | 43 ++++
 rtl/shift_step.sv | 27 ++
 rtl/shift_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the multicycle shift sequencer.
// Both the sequencer and its step unit import this package.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SRL = 2'b00,
    SH_SRA = 2'b01,
    SH_SLL = 2'b10
  } kind_t;

  localparam logic [4:0] LUI_AMOUNT = 5'd16;

  // lui forces a left shift; control[1] set selects SLL for both 10 and 11
  function automatic kind_t decode_kind(input logic lui, input logic [1:0] op);
    if (lui || op[1]) begin
      return SH_SLL;
    end else if (op[0]) begin
      return SH_SRA;
    end else begin
      return SH_SRL;
    end
  endfunction

  function automatic logic [4:0] decode_amount(input logic       lui,
                                               input logic       from_reg,
                                               input logic [4:0] reg_amount,
                                               input logic [4:0] shamt);
    if (lui) begin
      return LUI_AMOUNT;
    end else if (from_reg) begin
      return reg_amount;
    end else begin
      return shamt;
    end
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift engine: shifts 32 bits by 0..STEP positions.
// Only the amounts STEP or below are decoded, so the mux stays narrow.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [31:0] din,
  input  kind_t       kind,
  input  logic [5:0]  amt,
  output logic [31:0] dout
);

  always_comb begin
    dout = din;
    for (int i = 1; i <= STEP; i++) begin
      if (amt == 6'(i)) begin
        case (kind)
          SH_SRA:  dout = 32'($signed(din) >>> i);
          SH_SLL:  dout = din << i;
          default: dout = din >> i;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multicycle shift sequencer: latches an operand and shifts it at most STEP
// bits per clock, signalling busy while in flight and a one-cycle done pulse.
module shift_seq
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  control,
  input  logic        lui,
  input  logic [4:0]  constshift,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [5:0] STEP_AMT = 6'(STEP);

  state_t      state;
  state_t      next_state;
  kind_t       kind;
  kind_t       new_kind;
  logic [31:0] acc;
  logic [31:0] step_out;
  logic [4:0]  remaining;
  logic [4:0]  rem_next;
  logic [4:0]  new_amount;
  logic [5:0]  step_amt;
  logic        accept;
  logic        unused_a;

  assign unused_a   = ^a[31:5];
  assign accept     = (state == IDLE) && start && !flush;
  assign new_kind   = decode_kind(lui, control[1:0]);
  assign new_amount = decode_amount(lui, control[2], a[4:0], constshift);

  // Widened to 6 bits so STEP=32 compares correctly against a 5-bit count
  assign step_amt = ({1'b0, remaining} < STEP_AMT) ? {1'b0, remaining} : STEP_AMT;
  assign rem_next = remaining - step_amt[4:0];

  shift_step #(
    .STEP (STEP)
  ) u_step (
    .din  (acc),
    .kind (kind),
    .amt  (step_amt),
    .dout (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = (new_amount != 5'd0) ? SHIFT : DONE;
        SHIFT:   if (rem_next == 5'd0) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // A flush freezes the accumulator where it is; the consumer discards it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      remaining <= '0;
      kind      <= SH_SRL;
    end else if (accept) begin
      acc       <= b;
      remaining <= new_amount;
      kind      <= new_kind;
    end else if (state == SHIFT && !flush) begin
      acc       <= step_out;
      remaining <= rem_next;
    end
  end

  assign result = acc;

endmodule
